// File: rtl/branch_predictor_nway.sv
`default_nettype none
// =============================================================================
// Module   : branch_predictor_nway
// Brief    : N-lane BTB + local-history/PHT predictor with a post-reset table
//            sweep and chained same-cycle commit training.
//            Optional macro PRED_BTB_TAG_EN adds BTB tag storage and compare.
// Revision : 1.0  initial release
// =============================================================================
module branch_predictor_nway #(
  parameter int FETCH_WIDTH  = 2,
  parameter int COMMIT_WIDTH = 2,
  parameter int ADDR_BITS    = 64,
  parameter int BTB_BITS     = 4,
  parameter int LHT_BITS     = 4,
  parameter int HIST_BITS    = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [FETCH_WIDTH*ADDR_BITS-1:0]  if_pc,
  input  logic [FETCH_WIDTH-1:0]            if_valid,
  input  logic [COMMIT_WIDTH-1:0]           cm_valid,
  input  logic [COMMIT_WIDTH-1:0]           cm_taken,
  input  logic [COMMIT_WIDTH*ADDR_BITS-1:0] cm_pc,
  input  logic [COMMIT_WIDTH*ADDR_BITS-1:0] cm_target,
  output logic                              pred_ready,
  output logic [FETCH_WIDTH-1:0]            pred_taken,
  output logic [FETCH_WIDTH-1:0]            btb_hit,
  output logic [FETCH_WIDTH*ADDR_BITS-1:0]  pred_target
);

  localparam int c_btb_depth = 1 << BTB_BITS;
  localparam int c_lht_depth = 1 << LHT_BITS;
  localparam int c_pht_depth = 1 << HIST_BITS;
  localparam int c_max_bl    = (c_btb_depth > c_lht_depth) ? c_btb_depth : c_lht_depth;
  localparam int c_sweep_d   = (c_max_bl > c_pht_depth) ? c_max_bl : c_pht_depth;
  localparam int c_idx_w     = (c_sweep_d > 1) ? $clog2(c_sweep_d) : 1;
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(c_sweep_d - 1);
`ifdef PRED_BTB_TAG_EN
  localparam int c_tag_w     = ADDR_BITS - BTB_BITS - 2;
`endif

  typedef enum logic [0:0] {
    S_INIT  = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_ready;

  logic [c_btb_depth-1:0] r_btb_valid;
  logic [ADDR_BITS-1:0]   r_btb_tgt [c_btb_depth];
`ifdef PRED_BTB_TAG_EN
  logic [c_tag_w-1:0]     r_btb_tag [c_btb_depth];
  logic [c_tag_w-1:0]     w_cm_tag  [COMMIT_WIDTH];
`endif
  logic [HIST_BITS-1:0]   r_lht [c_lht_depth];
  logic [1:0]             r_pht [c_pht_depth];

  logic [HIST_BITS-1:0]   w_lht_nxt [c_lht_depth];
  logic [1:0]             w_pht_nxt [c_pht_depth];
  logic [LHT_BITS-1:0]    w_cm_lidx [COMMIT_WIDTH];
  logic [BTB_BITS-1:0]    w_cm_bidx [COMMIT_WIDTH];
  logic                   w_commit_en;
  logic                   w_unused;

  assign w_unused    = ^{if_pc, cm_pc};
  assign w_commit_en = reset && (r_state == S_READY);
  assign pred_ready  = r_ready;

  function automatic logic [1:0] f_sat2(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    else       return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  // Sweep sequencer: D cycles of INIT after reset release, then READY.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_INIT;
      r_idx   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (r_idx == c_idx_last) begin
            r_state <= S_READY;
            r_ready <= 1'b1;
          end else begin
            r_idx <= r_idx + c_idx_w'(1);
          end
        end
        S_READY: r_ready <= 1'b1;
        default: r_state <= S_INIT;
      endcase
    end
  end

  for (genvar k = 0; k < COMMIT_WIDTH; k++) begin : g_cm_idx
    assign w_cm_lidx[k] = cm_pc[k*ADDR_BITS+2 +: LHT_BITS];
    assign w_cm_bidx[k] = cm_pc[k*ADDR_BITS+2 +: BTB_BITS];
`ifdef PRED_BTB_TAG_EN
    assign w_cm_tag[k]  = cm_pc[k*ADDR_BITS+BTB_BITS+2 +: c_tag_w];
`endif
  end

  // Lanes applied in ascending order so each lane sees earlier lanes' updates.
  always_comb begin
    w_lht_nxt = r_lht;
    w_pht_nxt = r_pht;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      if (w_commit_en && cm_valid[k]) begin
        w_pht_nxt[w_lht_nxt[w_cm_lidx[k]]] =
          f_sat2(w_pht_nxt[w_lht_nxt[w_cm_lidx[k]]], cm_taken[k]);
        w_lht_nxt[w_cm_lidx[k]] = {w_lht_nxt[w_cm_lidx[k]][HIST_BITS-2:0], cm_taken[k]};
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset && (r_state == S_INIT)) begin
      if (int'(r_idx) < c_btb_depth) r_btb_valid[r_idx[BTB_BITS-1:0]] <= 1'b0;
      if (int'(r_idx) < c_lht_depth) r_lht[r_idx[LHT_BITS-1:0]] <= '0;
      if (int'(r_idx) < c_pht_depth) r_pht[r_idx[HIST_BITS-1:0]] <= 2'b01;
    end else if (w_commit_en) begin
      r_lht <= w_lht_nxt;
      r_pht <= w_pht_nxt;
      // Later lanes overwrite earlier ones, so the highest taken lane wins.
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (cm_valid[k] && cm_taken[k]) begin
          r_btb_valid[w_cm_bidx[k]] <= 1'b1;
          r_btb_tgt[w_cm_bidx[k]]   <= cm_target[k*ADDR_BITS +: ADDR_BITS];
`ifdef PRED_BTB_TAG_EN
          r_btb_tag[w_cm_bidx[k]]   <= w_cm_tag[k];
`endif
        end
      end
    end
  end

  for (genvar k = 0; k < FETCH_WIDTH; k++) begin : g_lane
    logic [BTB_BITS-1:0] w_bidx;
    logic [LHT_BITS-1:0] w_lidx;
    logic                w_en;
    logic                w_hit;

    assign w_bidx = if_pc[k*ADDR_BITS+2 +: BTB_BITS];
    assign w_lidx = if_pc[k*ADDR_BITS+2 +: LHT_BITS];
    assign w_en   = r_ready && if_valid[k];
`ifdef PRED_BTB_TAG_EN
    assign w_hit  = r_btb_valid[w_bidx] &&
                    (r_btb_tag[w_bidx] == if_pc[k*ADDR_BITS+BTB_BITS+2 +: c_tag_w]);
`else
    assign w_hit  = r_btb_valid[w_bidx];
`endif
    assign pred_taken[k] = w_en && r_pht[r_lht[w_lidx]][1];
    assign btb_hit[k]    = w_en && w_hit;
    assign pred_target[k*ADDR_BITS +: ADDR_BITS] = w_en ? r_btb_tgt[w_bidx] : '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_nway.sv
`default_nettype none
// =============================================================================
// Module   : tb_branch_predictor_nway
// Brief    : Directed + randomized bench for branch_predictor_nway against an
//            array-based predictor model.
// Revision : 1.0  initial release
// =============================================================================
module tb_branch_predictor_nway;

  localparam int AW = 64;
  localparam int D  = 16;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [2*AW-1:0] if_pc = '0;
  logic [1:0]      if_valid = '0;
  logic [1:0]      cm_valid = '0;
  logic [1:0]      cm_taken = '0;
  logic [2*AW-1:0] cm_pc = '0;
  logic [2*AW-1:0] cm_target = '0;
  logic            pred_ready;
  logic [1:0]      pred_taken;
  logic [1:0]      btb_hit;
  logic [2*AW-1:0] pred_target;

  branch_predictor_nway dut (
    .clock      (clock),
    .reset      (reset),
    .if_pc      (if_pc),
    .if_valid   (if_valid),
    .cm_valid   (cm_valid),
    .cm_taken   (cm_taken),
    .cm_pc      (cm_pc),
    .cm_target  (cm_target),
    .pred_ready (pred_ready),
    .pred_taken (pred_taken),
    .btb_hit    (btb_hit),
    .pred_target(pred_target)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state
  int          m_lht [D];
  int          m_pht [D];
  bit          m_bv  [D];
  bit          m_bw  [D];
  logic [63:0] m_bt  [D];
  logic [63:0] m_btag[D];
  int          m_init_cnt = 0;
  bit          m_ready = 1'b0;

  logic            s_ready;
  logic [1:0]      s_taken;
  logic [1:0]      s_hit;
  logic [2*AW-1:0] s_tgt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int idx_of(input logic [63:0] pc);
    return int'((pc >> 2) % 64'(D));
  endfunction

  function automatic void model_edge();
    if (!reset) begin
      m_ready    = 1'b0;
      m_init_cnt = 0;
    end else if (!m_ready) begin
      m_init_cnt++;
      if (m_init_cnt == D) begin
        m_ready = 1'b1;
        for (int i = 0; i < D; i++) begin
          m_lht[i] = 0;
          m_pht[i] = 1;
          m_bv[i]  = 1'b0;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (cm_valid[k]) begin
          logic [63:0] pc;
          int li, h, t;
          pc = cm_pc[k*AW +: AW];
          li = idx_of(pc);
          h  = m_lht[li];
          t  = cm_taken[k] ? 1 : 0;
          if (t == 1) m_pht[h] = (m_pht[h] < 3) ? m_pht[h] + 1 : 3;
          else        m_pht[h] = (m_pht[h] > 0) ? m_pht[h] - 1 : 0;
          m_lht[li] = (h * 2 + t) % D;
          if (t == 1) begin
            m_bv[li]   = 1'b1;
            m_bw[li]   = 1'b1;
            m_bt[li]   = cm_target[k*AW +: AW];
            m_btag[li] = pc >> 6;
          end
        end
      end
    end
  endfunction

  task automatic cycle(input logic rst, input logic [1:0] ifv, input logic [2*AW-1:0] ifpc,
                       input logic [1:0] cv, input logic [1:0] ct,
                       input logic [2*AW-1:0] cpc, input logic [2*AW-1:0] ctgt);
    @(negedge clock);
    reset = rst; if_valid = ifv; if_pc = ifpc;
    cm_valid = cv; cm_taken = ct; cm_pc = cpc; cm_target = ctgt;
    #1;
    s_ready = pred_ready; s_taken = pred_taken; s_hit = btb_hit; s_tgt = pred_target;
    chk("ready", 64'(pred_ready), 64'(m_ready));
    for (int k = 0; k < 2; k++) begin
      logic [63:0] pc;
      int bi;
      bit en, et, eh;
      pc = ifpc[k*AW +: AW];
      bi = idx_of(pc);
      en = m_ready && ifv[k];
      et = en && (m_pht[m_lht[bi]] >= 2);
`ifdef PRED_BTB_TAG_EN
      eh = en && m_bv[bi] && (m_btag[bi] == (pc >> 6));
`else
      eh = en && m_bv[bi];
`endif
      chk($sformatf("taken%0d", k), 64'(pred_taken[k]), 64'(et));
      chk($sformatf("hit%0d", k), 64'(btb_hit[k]), 64'(eh));
      if (!en)             chk($sformatf("tgt%0d", k), pred_target[k*AW +: AW], 64'd0);
      else if (m_bw[bi])   chk($sformatf("tgt%0d", k), pred_target[k*AW +: AW], m_bt[bi]);
    end
    @(posedge clock);
    model_edge();
  endtask

  function automatic logic [63:0] rpc();
    return 64'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
  endfunction

  function automatic logic [2*AW-1:0] rpc2();
    return {rpc(), rpc()};
  endfunction

  function automatic logic [2*AW-1:0] rtgt2();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Returns the number of released cycles before pred_ready is seen high.
  task automatic wait_ready(output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 2'($urandom), rpc2(), (i < 16) ? 2'($urandom) : 2'b00,
            2'($urandom), rpc2(), rtgt2());
      if (s_ready) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic look(input logic [63:0] pc0, input logic [63:0] pc1);
    cycle(1'b1, 2'b11, {pc1, pc0}, 2'b00, 2'b00, '0, '0);
  endtask

  task automatic commit(input logic [1:0] cv, input logic [1:0] ct,
                        input logic [63:0] pc0, input logic [63:0] pc1,
                        input logic [63:0] t0, input logic [63:0] t1);
    cycle(1'b1, 2'b00, '0, cv, ct, {pc1, pc0}, {t1, t0});
  endtask

  task automatic restart();
    int n;
    repeat (2) cycle(1'b0, 2'b11, rpc2(), 2'b11, 2'b11, rpc2(), rtgt2());
    wait_ready(n);
    chk("init_len", 64'(n), 64'd16);
  endtask

  initial begin
    int n;
    // Power-up reset and full sweep
    repeat (3) cycle(1'b0, 2'($urandom), rpc2(), 2'($urandom), 2'($urandom), rpc2(), rtgt2());
    wait_ready(n);
    chk("init_len", 64'(n), 64'd16);

    // Reset re-asserted at INIT cycle 8 restarts the sweep
    cycle(1'b0, 2'b00, '0, 2'b00, 2'b00, '0, '0);
    repeat (8) cycle(1'b1, 2'b11, rpc2(), 2'b11, 2'b11, rpc2(), rtgt2());
    cycle(1'b0, 2'b00, '0, 2'b00, 2'b00, '0, '0);
    wait_ready(n);
    chk("reinit_len", 64'(n), 64'd16);

    // Four taken commits drive history 1111; PHT[15] still weakly not-taken
    repeat (4) commit(2'b01, 2'b01, 64'h0, 64'h0, 64'h1000, 64'h0);
    look(64'h0, 64'h0);
    chk("pht15_taken", 64'(s_taken[0]), 64'd0);
    chk("pht15_hit", 64'(s_hit[0]), 64'd1);

    // Two taken commits of 0x100 -> strongly taken, target 0x400
    repeat (2) commit(2'b01, 2'b01, 64'h100, 64'h0, 64'h400, 64'h0);
    look(64'h100, 64'h0);
    chk("b100_taken", 64'(s_taken[0]), 64'd1);
    chk("b100_hit", 64'(s_hit[0]), 64'd1);
    chk("b100_tgt", s_tgt[63:0], 64'h400);

    // Same LHT entry twice in one cycle; not-taken lane leaves BTB alone
    restart();
    commit(2'b11, 2'b01, 64'h40, 64'h40, 64'hA0, 64'hB0);
    look(64'h40, 64'h40);
    chk("dup_hit", 64'(s_hit[0]), 64'd1);
    chk("dup_tgt", s_tgt[63:0], 64'hA0);
    chk("dup_taken", 64'(s_taken[0]), 64'd0);

    // Same BTB index, both taken: lane1 wins
    commit(2'b11, 2'b11, 64'h40, 64'h80, 64'hC0, 64'hD0);
    look(64'h40, 64'h80);
    chk("win_hit1", 64'(s_hit[1]), 64'd1);
    chk("win_tgt1", s_tgt[127:64], 64'hD0);
    chk("win_tgt0", s_tgt[63:0], 64'hD0);
`ifdef PRED_BTB_TAG_EN
    chk("win_hit0", 64'(s_hit[0]), 64'd0);
`else
    chk("win_hit0", 64'(s_hit[0]), 64'd1);
`endif

    // Aliased lookup against a fresh table
    restart();
    commit(2'b01, 2'b01, 64'h40, 64'h0, 64'hE0, 64'h0);
    look(64'h80, 64'h40);
`ifdef PRED_BTB_TAG_EN
    chk("alias_hit", 64'(s_hit[0]), 64'd0);
`else
    chk("alias_hit", 64'(s_hit[0]), 64'd1);
`endif
    chk("alias_tgt", s_tgt[63:0], 64'hE0);

    // Commit and lookup of the same entry in one cycle: no bypass
    cycle(1'b1, 2'b01, {64'h0, 64'h204}, 2'b01, 2'b01, {64'h0, 64'h204}, {64'h0, 64'h300});
    chk("nobyp_hit", 64'(s_hit[0]), 64'd0);
    look(64'h204, 64'h0);
    chk("nobyp_hit_next", 64'(s_hit[0]), 64'd1);
    chk("nobyp_tgt_next", s_tgt[63:0], 64'h300);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 299) != 0), 2'($urandom), rpc2(),
            2'($urandom), 2'($urandom), rpc2(), rtgt2());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
